// File: rtl/sopc_system_mul_seq.sv
// ---------------------------------------------------------------------------
// sopc_system_mul_seq
//
// Sequential multiply unit. Multiplies two DATA_W operands by consuming src2
// in SLICE_W-bit slices, adding one DATA_W x SLICE_W partial product per
// cycle into an accumulator. It returns either the low product word or a
// signed/unsigned high word (Nios II mul / mulxss / mulxsu / mulxuu) through
// a valid/ready handshake.
//
// Optional feature macro: SOPC_MUL_SEQ_HI_EN
//   defined   : all four modes, 2*DATA_W accumulator, high-word correction
//   undefined : mode ignored, DATA_W accumulator, result is always low word
//   Latency and handshake are the same in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   request strobe, accepted when in_valid & in_ready
//   in_ready   out  high while idle
//   mode       in   0 MUL, 1 MULXSS, 2 MULXSU, 3 MULXUU
//   src1       in   multiplicand, captured on accept
//   src2       in   multiplier, captured on accept
//   out_valid  out  one-cycle pulse marking a new result
//   result     out  selected product word, held until the next out_valid
//   busy       out  complement of in_ready
// ---------------------------------------------------------------------------
module sopc_system_mul_seq #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    localparam int N  = DATA_W / SLICE_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
`ifdef SOPC_MUL_SEQ_HI_EN
    localparam int ACC_W = 2 * DATA_W;
`else
    localparam int ACC_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q;
    logic [DATA_W-1:0]   src1_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [ACC_W-1:0]    acc_q;
    logic [DATA_W-1:0]   result_q;
    logic                out_valid_q;
    logic                lastSlice;
    logic [ACC_W-1:0]    partialProd;
    logic [DATA_W-1:0]   finWord;
    int                  shAmt;

`ifdef SOPC_MUL_SEQ_HI_EN
    logic [DATA_W-1:0]   src2_q;
    logic [1:0]          mode_q;
    logic                s1neg_q;
    logic                s2neg_q;
    logic [DATA_W-1:0]   hiWord;
`else
    logic                unusedMode;
    assign unusedMode = ^mode;
`endif

    assign lastSlice = (idx_q == IW'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one accept cycle, N accumulate cycles, one finish cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = ACC;
            ACC:     if (lastSlice) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The multiplier register is shifted right each cycle, so the current
    // slice is always its low SLICE_W bits; the partial product is moved up
    // to the slice's weight in the accumulator. The product is formed at
    // accumulator width so the narrow build simply wraps mod 2^DATA_W.
    always_comb begin
        shAmt       = int'(idx_q) * SLICE_W;
        partialProd = (ACC_W'(src1_q) * ACC_W'(mplier_q[SLICE_W-1:0])) << shAmt;
    end

`ifdef SOPC_MUL_SEQ_HI_EN
    // The accumulator holds the unsigned product. Treating a negative
    // operand as signed subtracts 2^DATA_W times the other operand, which
    // only affects the upper word.
    always_comb begin
        hiWord = acc_q[ACC_W-1:DATA_W];
        if (s1neg_q) hiWord = hiWord - src2_q;
        if (s2neg_q) hiWord = hiWord - src1_q;
        finWord = (mode_q == 2'd0) ? acc_q[DATA_W-1:0] : hiWord;
    end
`else
    assign finWord = acc_q;
`endif

    // Datapath: capture operands on accept, accumulate one slice per cycle,
    // register the selected word and pulse out_valid when finishing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            src1_q      <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef SOPC_MUL_SEQ_HI_EN
            src2_q      <= '0;
            mode_q      <= 2'd0;
            s1neg_q     <= 1'b0;
            s2neg_q     <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        src1_q   <= src1;
                        mplier_q <= src2;
                        acc_q    <= '0;
                        idx_q    <= '0;
`ifdef SOPC_MUL_SEQ_HI_EN
                        src2_q   <= src2;
                        mode_q   <= mode;
                        s1neg_q  <= src1[DATA_W-1] & ((mode == 2'd1) || (mode == 2'd2));
                        s2neg_q  <= src2[DATA_W-1] & (mode == 2'd1);
`endif
                    end
                end
                ACC: begin
                    acc_q    <= acc_q + partialProd;
                    mplier_q <= mplier_q >> SLICE_W;
                    idx_q    <= idx_q + 1'b1;
                end
                FIN: begin
                    result_q    <= finWord;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_sopc_system_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_sopc_system_mul_seq
//
// Self-checking bench for sopc_system_mul_seq. Two instances are exercised:
// unit 0 with the default slicing (N = 2) and unit 1 with SLICE_W = 8
// (N = 4). Expected products come from a 64-bit arithmetic reference model
// that honours SOPC_MUL_SEQ_HI_EN the same way the design build does.
// ---------------------------------------------------------------------------
module tb_sopc_system_mul_seq;

    logic        clk;
    logic        reset_n;
    logic        inValid   [2];
    logic        inReady   [2];
    logic [1:0]  modeIn    [2];
    logic [31:0] src1In    [2];
    logic [31:0] src2In    [2];
    logic        outValid  [2];
    logic [31:0] resultOut [2];
    logic        busyOut   [2];

    int assertCount = 0;
    int failCount   = 0;

    sopc_system_mul_seq #(.DATA_W(32), .SLICE_W(16)) dut0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (inValid[0]),
        .in_ready  (inReady[0]),
        .mode      (modeIn[0]),
        .src1      (src1In[0]),
        .src2      (src2In[0]),
        .out_valid (outValid[0]),
        .result    (resultOut[0]),
        .busy      (busyOut[0])
    );

    sopc_system_mul_seq #(.DATA_W(32), .SLICE_W(8)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (inValid[1]),
        .in_ready  (inReady[1]),
        .mode      (modeIn[1]),
        .src1      (src1In[1]),
        .src2      (src2In[1]),
        .out_valid (outValid[1]),
        .result    (resultOut[1]),
        .busy      (busyOut[1])
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    // Reference product: sign-extend or zero-extend to 64 bits according to
    // the mode and take the requested half of the full product.
    function automatic logic [31:0] refMul(input logic [1:0] m, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = ((m == 2'd1) || (m == 2'd2)) ? {{32{a[31]}}, a} : {32'd0, a};
        sb = (m == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = sa * sb;
`ifdef SOPC_MUL_SEQ_HI_EN
        return (m == 2'd0) ? p[31:0] : p[63:32];
`else
        return p[31:0];
`endif
    endfunction

    // Cycles from accept to out_valid: one per slice plus the finish cycle.
    function automatic int latExp(input int u);
        return (u == 0) ? 3 : 5;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request on unit u and wait (bounded) for its result.
    // Operands are scrambled right after accept to confirm they were captured.
    task automatic applyStimulus(input int u, input logic [1:0] m, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] res,
                                 output int lat, output int busyCycles);
        int guard;
        bit found;
        @(negedge clk);
        guard = 0;
        while (!inReady[u] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_req", 32'(inReady[u]), 32'd1);
        inValid[u] = 1'b1;
        modeIn[u]  = m;
        src1In[u]  = a;
        src2In[u]  = b;
        @(posedge clk);
        #1;
        inValid[u] = 1'b0;
        modeIn[u]  = 2'($urandom);
        src1In[u]  = $urandom;
        src2In[u]  = $urandom;
        busyCycles = busyOut[u] ? 1 : 0;
        lat        = 0;
        res        = 'x;
        found      = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (outValid[u]) begin
                res   = resultOut[u];
                found = 1'b1;
                break;
            end
            if (busyOut[u]) busyCycles++;
        end
        checkOutput("result_seen", 32'(found), 32'd1);
        if (found) begin
            checkOutput("busy_low_at_valid", 32'(busyOut[u]), 32'd0);
            @(posedge clk);
            #1;
            checkOutput("out_valid_single", 32'(outValid[u]), 32'd0);
            checkOutput("result_held", resultOut[u], res);
        end
    endtask

    task automatic runCheck(input int u, input logic [1:0] m, input logic [31:0] a,
                            input logic [31:0] b, input string tag, output logic [31:0] res);
        int lat, bc;
        applyStimulus(u, m, a, b, res, lat, bc);
        checkOutput({tag, "_result"}, res, refMul(m, a, b));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(latExp(u)));
        checkOutput({tag, "_busy_cycles"}, 32'(bc), 32'(latExp(u)));
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    initial begin
        logic [31:0] res;
        logic [31:0] resA, resB;
        logic [31:0] expVal;
        int          cnt, cycA, cycB, sawValid;
        logic [31:0] got [4];
        int          at  [4];
        vec_t        vecs [4];

        vecs[0] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[2] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[3] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        for (int u = 0; u < 2; u++) begin
            inValid[u] = 1'b0;
            modeIn[u]  = 2'd0;
            src1In[u]  = '0;
            src2In[u]  = '0;
        end

        // Reset state, both while asserted and after release.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checkOutput("rst_in_ready", 32'(inReady[u]), 32'd1);
            checkOutput("rst_busy", 32'(busyOut[u]), 32'd0);
            checkOutput("rst_out_valid", 32'(outValid[u]), 32'd0);
            checkOutput("rst_result", resultOut[u], 32'd0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", 32'(inReady[0]), 32'd1);
        checkOutput("post_rst_out_valid", 32'(outValid[0]), 32'd0);

        // Low word, default slicing.
        runCheck(0, 2'd0, 32'h0001_2345, 32'h0000_0010, "low_word", res);
        checkOutput("low_word_const", res, 32'h0012_3450);

        // High-word modes against fixed expected values.
        for (int i = 0; i < 4; i++) begin
`ifdef SOPC_MUL_SEQ_HI_EN
            expVal = vecs[i].expHi;
`else
            expVal = vecs[i].expLo;
`endif
            runCheck(0, vecs[i].m, vecs[i].a, vecs[i].b, "hi_vec_n2", res);
            checkOutput("hi_vec_n2_const", res, expVal);
            runCheck(1, vecs[i].m, vecs[i].a, vecs[i].b, "hi_vec_n4", res);
            checkOutput("hi_vec_n4_const", res, expVal);
        end

        // Four-slice unit, small operands.
        runCheck(1, 2'd0, 32'h0000_0003, 32'h0000_0005, "n4_low", res);
        checkOutput("n4_low_const", res, 32'h0000_000F);

        // Random operands and modes on both units.
        for (int i = 0; i < 16; i++) begin
            runCheck(i % 2, 2'($urandom), $urandom, $urandom, "random", res);
        end

        // Request held high while busy: exactly two results, the second
        // accepted in the first one's out_valid cycle.
        @(negedge clk);
        resA = $urandom;
        resB = $urandom;
        inValid[0] = 1'b1;
        modeIn[0]  = 2'd3;
        src1In[0]  = resA;
        src2In[0]  = resB;
        @(posedge clk);
        #1;
        src1In[0] = resB;
        src2In[0] = 32'h0000_0003;
        modeIn[0] = 2'd0;
        cnt = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 4) inValid[0] = 1'b0;
            if (outValid[0] && cnt < 4) begin
                got[cnt] = resultOut[0];
                at[cnt]  = cyc;
                cnt++;
            end
        end
        checkOutput("busy_req_count", 32'(cnt), 32'd2);
        cycA = (cnt > 0) ? at[0] : -1;
        cycB = (cnt > 1) ? at[1] : -1;
        checkOutput("busy_req_first_cycle", 32'(cycA), 32'd3);
        checkOutput("busy_req_second_cycle", 32'(cycB), 32'd7);
        if (cnt > 1) begin
            checkOutput("busy_req_first_result", got[0], refMul(2'd3, resA, resB));
            checkOutput("busy_req_second_result", got[1], refMul(2'd0, resB, 32'h0000_0003));
        end

        // Reset one cycle after accept abandons the operation.
        @(negedge clk);
        inValid[0] = 1'b1;
        modeIn[0]  = 2'd0;
        src1In[0]  = 32'h0000_1234;
        src2In[0]  = 32'h0000_0100;
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        sawValid = outValid[0] ? 1 : 0;
        checkOutput("mid_rst_in_ready", 32'(inReady[0]), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk);
            #1;
            if (outValid[0]) sawValid++;
        end
        checkOutput("mid_rst_no_valid", 32'(sawValid), 32'd0);
        checkOutput("mid_rst_result", resultOut[0], 32'd0);
        checkOutput("mid_rst_ready", 32'(inReady[0]), 32'd1);
        runCheck(0, 2'd0, 32'h0000_0007, 32'h0000_0006, "after_rst", res);
        checkOutput("after_rst_const", res, 32'h0000_002A);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
